// File: rtl/simeck_decrypt_iter.sv
// Iterative Simeck decryption core (32/64, 48/96, 64/128). The master key is expanded once into
// a round-key store; blocks then decrypt at one round per clock, walking the keys backwards.
module simeck_decrypt_iter #(
   parameter int WORD_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic [4*WORD_W-1:0]   key_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*WORD_W-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*WORD_W-1:0]   out_data,
   output logic                  busy
);

   localparam int ROUNDS = (WORD_W == 16) ? 32 : (WORD_W == 24) ? 36 : 44;
   localparam bit ZSEQ = (WORD_W == 32);
   localparam int CW = $clog2(ROUNDS);
   localparam int DEPTH = 1 << CW;
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
   localparam logic [WORD_W-1:0] C = {{(WORD_W-2){1'b1}}, 2'b00};
   localparam logic [5:0] SEED = ZSEQ ? 6'b111111 : 6'b011111;

   typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_READY, S_DECRYPT, S_DONE} state_t;

   state_t              r_state, w_nxt_state;
   logic [WORD_W-1:0]   r_t0, r_t1, r_t2, r_t3, r_l, r_r;
   logic [WORD_W-1:0]   r_rk [DEPTH];
   logic [5:0]          r_lfsr;
   logic [CW-1:0]       r_idx, r_cnt;
   logic                r_rk_vld;
   logic                r_key_ready, r_in_ready, r_out_valid, r_busy;
   logic [2*WORD_W-1:0] r_out_data;
   logic                w_key_fire, w_in_fire;
   logic [WORD_W-1:0]   w_t3_nxt, w_r_nxt;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int s);
      return (x << s) | (x >> (WORD_W - s));
   endfunction

   function automatic logic [WORD_W-1:0] f_rnd(input logic [WORD_W-1:0] x);
      return (x & rotl(x, 5)) ^ rotl(x, 1);
   endfunction

   // z0: x^5+x^2+1 in bits [4:0]; z1: x^6+x+1 in bits [5:0]. Output is always bit 0.
   function automatic logic [5:0] lfsr_step(input logic [5:0] s);
      if (ZSEQ) return {s[1] ^ s[0], s[5:1]};
      else      return {1'b0, s[2] ^ s[0], s[4:1]};
   endfunction

   assign w_t3_nxt = r_t0 ^ f_rnd(r_t1) ^ C ^ {{(WORD_W-1){1'b0}}, r_lfsr[0]};
   assign w_r_nxt  = r_l ^ f_rnd(r_r) ^ r_rk[r_cnt];

   always_comb begin
      w_key_fire  = key_valid & r_key_ready;
      w_in_fire   = in_valid & r_in_ready & r_rk_vld & ~w_key_fire;
      w_nxt_state = r_state;
      case (r_state)
         S_IDLE:    if (w_key_fire) w_nxt_state = S_EXPAND;
         S_EXPAND:  if (r_idx == LAST) w_nxt_state = S_READY;
         S_READY:   if (w_key_fire) w_nxt_state = S_EXPAND;
                    else if (w_in_fire) w_nxt_state = S_DECRYPT;
         S_DECRYPT: if (r_cnt == '0) w_nxt_state = S_DONE;
         S_DONE:    if (out_ready) w_nxt_state = S_READY;
         default:   w_nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nxt_state;
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_ready <= 1'b1;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_data  <= '0;
         r_rk_vld    <= 1'b0;
         r_idx       <= '0;
         r_cnt       <= '0;
      end else begin
         r_key_ready <= (w_nxt_state == S_IDLE) || (w_nxt_state == S_READY);
         r_in_ready  <= (w_nxt_state == S_READY);
         r_out_valid <= (w_nxt_state == S_DONE);
         r_busy      <= (w_nxt_state == S_EXPAND) || (w_nxt_state == S_DECRYPT);
         if (w_key_fire) begin
            r_rk_vld <= 1'b0;
            r_idx    <= '0;
         end else if (r_state == S_EXPAND) begin
            if (r_idx == LAST) r_rk_vld <= 1'b1;
            else               r_idx    <= r_idx + 1'b1;
         end
         if (w_in_fire)
            r_cnt <= LAST;
         else if ((r_state == S_DECRYPT) && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
         if ((r_state == S_DECRYPT) && (r_cnt == '0))
            r_out_data <= {r_r, w_r_nxt};
      end
   end

   always_ff @(posedge clk) begin
      if (w_key_fire) begin
         {r_t3, r_t2, r_t1, r_t0} <= key_in;
         r_lfsr <= SEED;
      end else if (r_state == S_EXPAND) begin
         r_rk[r_idx] <= r_t0;
         r_t0        <= r_t1;
         r_t1        <= r_t2;
         r_t2        <= r_t3;
         r_t3        <= w_t3_nxt;
         r_lfsr      <= lfsr_step(r_lfsr);
      end
      if (w_in_fire) begin
         {r_l, r_r} <= in_data;
      end else if (r_state == S_DECRYPT) begin
         r_l <= r_r;
         r_r <= w_r_nxt;
      end
   end

   assign key_ready = r_key_ready;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;

endmodule

// File: tb/tb_simeck_decrypt_iter.sv
// Directed bench for simeck_decrypt_iter: one instance per word width, checked against the
// published Simeck test vectors plus handshake, latency, backpressure and reset scenarios.
module tb_simeck_decrypt_iter;

   localparam logic [127:0] K16  = 128'h1918111009080100;
   localparam logic [63:0]  CT16 = 64'h770d2c76;
   localparam logic [63:0]  PT16 = 64'h65656877;
   localparam logic [127:0] K24  = 128'h1a19181211100a0908020100;
   localparam logic [63:0]  CT24 = 64'hf3cf25e33b36;
   localparam logic [63:0]  PT24 = 64'h72696320646e;
   localparam logic [127:0] K32  = 128'h1b1a1918131211100b0a090803020100;
   localparam logic [63:0]  CT32 = 64'h45ce69025f7ab7ed;
   localparam logic [63:0]  PT32 = 64'h656b696c20646e75;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   rst, kv, iv, ordy, kr, ir, ov, bs;
   logic [63:0]  key16;
   logic [95:0]  key24;
   logic [127:0] key32;
   logic [31:0]  ct16, od16;
   logic [47:0]  ct24, od24;
   logic [63:0]  ct32, od32;
   int n_chk = 0;
   int n_bad = 0;

   simeck_decrypt_iter #(.WORD_W(16)) u_dut16 (
      .clk(clk), .rst(rst[0]), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(key16),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_data(ct16), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_data(od16), .busy(bs[0]));

   simeck_decrypt_iter #(.WORD_W(24)) u_dut24 (
      .clk(clk), .rst(rst[1]), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(key24),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_data(ct24), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_data(od24), .busy(bs[1]));

   simeck_decrypt_iter #(.WORD_W(32)) u_dut32 (
      .clk(clk), .rst(rst[2]), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(key32),
      .in_valid(iv[2]), .in_ready(ir[2]), .in_data(ct32), .out_valid(ov[2]),
      .out_ready(ordy[2]), .out_data(od32), .busy(bs[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] get_od(input int d);
      case (d)
         0:       return {32'h0, od16};
         1:       return {16'h0, od24};
         default: return od32;
      endcase
   endfunction

   task automatic set_key(input int d, input logic [127:0] k);
      case (d)
         0:       key16 = k[63:0];
         1:       key24 = k[95:0];
         default: key32 = k;
      endcase
   endtask

   task automatic set_ct(input int d, input logic [63:0] c);
      case (d)
         0:       ct16 = c[31:0];
         1:       ct24 = c[47:0];
         default: ct32 = c;
      endcase
   endtask

   task automatic load_key(input int d, input logic [127:0] k, output int lat, output int klow);
      int n;
      n = 0;
      while (!kr[d] && n < 200) begin tick(); n++; end
      set_key(d, k);
      kv[d] = 1'b1;
      tick();
      kv[d] = 1'b0;
      lat  = 0;
      klow = 0;
      while (!ir[d] && lat < 200) begin
         if (!kr[d]) klow++;
         tick();
         lat++;
      end
   endtask

   task automatic decrypt(input int d, input logic [63:0] c, output logic [63:0] pt, output int lat);
      int n;
      n = 0;
      while (!ir[d] && n < 200) begin tick(); n++; end
      set_ct(d, c);
      iv[d] = 1'b1;
      tick();
      iv[d] = 1'b0;
      lat = 0;
      while (!ov[d] && lat < 200) begin tick(); lat++; end
      pt = get_od(d);
   endtask

   initial begin
      int lat, klow, seen;
      logic [63:0] pt;
      rst = '1; kv = '0; iv = '0; ordy = '1;
      key16 = '0; key24 = '0; key32 = '0;
      ct16 = '0; ct24 = '0; ct32 = '0;
      repeat (3) tick();
      rst = '0;

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_kr%0d", d), 64'(kr[d]), 64'd1);
         chk($sformatf("rst_ir%0d", d), 64'(ir[d]), 64'd0);
         chk($sformatf("rst_ov%0d", d), 64'(ov[d]), 64'd0);
         chk($sformatf("rst_bs%0d", d), 64'(bs[d]), 64'd0);
         chk($sformatf("rst_od%0d", d), get_od(d), 64'd0);
      end

      // Same-cycle key and ciphertext in READY: key wins.
      load_key(0, 128'h0, lat, klow);
      chk("t5_junk_lat", 64'(lat), 64'd32);
      set_key(0, K16);
      set_ct(0, CT16);
      kv[0] = 1'b1; iv[0] = 1'b1;
      tick();
      kv[0] = 1'b0; iv[0] = 1'b0;
      chk("t5_kr", 64'(kr[0]), 64'd0);
      chk("t5_ir", 64'(ir[0]), 64'd0);
      chk("t5_busy", 64'(bs[0]), 64'd1);
      lat = 0; seen = 0;
      while (!ir[0] && lat < 200) begin
         if (ov[0]) seen = 1;
         tick();
         lat++;
      end
      chk("t5_expand_lat", 64'(lat), 64'd32);
      chk("t5_no_out", 64'(seen), 64'd0);
      decrypt(0, CT16, pt, lat);
      chk("t5_pt", pt, PT16);
      chk("t5_lat", 64'(lat), 64'd32);
      tick();
      chk("t5_ov_drop", 64'(ov[0]), 64'd0);
      chk("t5_ir_back", 64'(ir[0]), 64'd1);

      // Simeck32/64 vector, re-keyed from READY.
      load_key(0, K16, lat, klow);
      chk("t1_expand_lat", 64'(lat), 64'd32);
      chk("t1_kr_low", 64'(klow), 64'd32);
      decrypt(0, CT16, pt, lat);
      chk("t1_pt", pt, PT16);
      chk("t1_lat", 64'(lat), 64'd32);
      tick();

      // Backpressure in DONE, then a second block under the same key.
      ordy[0] = 1'b0;
      decrypt(0, CT16, pt, lat);
      chk("t4_pt", pt, PT16);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_od", get_od(0), PT16);
         chk("t4_hold_ov", 64'(ov[0]), 64'd1);
         chk("t4_hold_ir", 64'(ir[0]), 64'd0);
      end
      ordy[0] = 1'b1;
      tick();
      chk("t4_ov_drop", 64'(ov[0]), 64'd0);
      chk("t4_ir_back", 64'(ir[0]), 64'd1);
      decrypt(0, CT16, pt, lat);
      chk("t4_pt2", pt, PT16);
      chk("t4_lat2", 64'(lat), 64'd32);
      tick();

      // Simeck48/96 and Simeck64/128 vectors.
      load_key(1, K24, lat, klow);
      chk("t2_expand_lat", 64'(lat), 64'd36);
      chk("t2_kr_low", 64'(klow), 64'd36);
      decrypt(1, CT24, pt, lat);
      chk("t2_pt", pt, PT24);
      chk("t2_lat", 64'(lat), 64'd36);
      load_key(2, K32, lat, klow);
      chk("t3_expand_lat", 64'(lat), 64'd44);
      chk("t3_kr_low", 64'(klow), 64'd44);
      decrypt(2, CT32, pt, lat);
      chk("t3_pt", pt, PT32);
      chk("t3_lat", 64'(lat), 64'd44);

      // Reset in the middle of DECRYPT.
      set_ct(0, CT16);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (10) tick();
      chk("t6d_busy", 64'(bs[0]), 64'd1);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      chk("t6d_ov", 64'(ov[0]), 64'd0);
      chk("t6d_ir", 64'(ir[0]), 64'd0);
      chk("t6d_kr", 64'(kr[0]), 64'd1);
      chk("t6d_bs", 64'(bs[0]), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (ov[0] || ir[0]) seen = 1;
         tick();
      end
      chk("t6d_stay_idle", 64'(seen), 64'd0);

      // Reset in the middle of EXPAND.
      set_key(0, K16);
      kv[0] = 1'b1;
      tick();
      kv[0] = 1'b0;
      repeat (10) tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      chk("t6e_kr", 64'(kr[0]), 64'd1);
      chk("t6e_ir", 64'(ir[0]), 64'd0);
      chk("t6e_bs", 64'(bs[0]), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (ir[0] || bs[0]) seen = 1;
         tick();
      end
      chk("t6e_stay_idle", 64'(seen), 64'd0);

      load_key(0, K16, lat, klow);
      chk("t6_rekey_lat", 64'(lat), 64'd32);
      decrypt(0, CT16, pt, lat);
      chk("t6_pt", pt, PT16);
      chk("t6_lat", 64'(lat), 64'd32);
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
